matrix_inv_sequencer: RTL
=========================

Name: matrix_inv_sequencer

Overview:
- Upstream control stage for matrixInversion; generates its `cnt` enable and the 41 sticky step enables `cnt0`..`cnt40` from a single start pulse.
- Top level wires `cnt_step[k]` to matrixInversion port `cnt<k>`.
- Adds programmable settle/step timing, hold, abort and a done flag, so the inverter runs without free-running timed stimulus.

Parameters:
- SETTLE_CYCLES, 10, clocks between `cnt` rising and `cnt_step[0]` rising; legal range is 1 or more.
- STEP_CYCLES, 1, clocks between successive `cnt_step[k]` and `cnt_step[k+1]` rising edges; legal range is 1 or more.
- NUM_STEPS, 41, number of step enables, covering cnt0..cnt40; fixed for the 5x5 inverter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin an inversion run.
- abort  input  1  synchronous abort of the current run.
- hold  input  1  freezes step progression while high.
- cnt  output  1  inverter global enable; drives matrixInversion `cnt`.
- cnt_step  output  NUM_STEPS  thermometer of step enables; bit k drives matrixInversion `cnt<k>`.
- step_idx  output  6  number of `cnt_step` bits currently set, 0..41.
- busy  output  1  high from `cnt` rise until `done` rises.
- done  output  1  high once `cnt_step[40]` is set; held.

Behaviour:
- Reset values: `cnt`=0, `cnt_step`=0, `step_idx`=0, `busy`=0, `done`=0, state IDLE, internal counter=0.
- Priority at each edge: `rst` > `abort` > `hold` > normal progression.
- FSM states: IDLE, REARM, SETTLE, STEP, DONE.
- IDLE: all outputs 0.
  - `start`=1 → SETTLE at the next edge; that edge sets `cnt`=1 and `busy`=1 and clears the counter.
- SETTLE: counter increments each unheld cycle.
  - When counter reaches SETTLE_CYCLES-1, the next edge sets `cnt_step[0]`, sets `step_idx`=1 and enters STEP with the counter cleared.
  - `cnt_step[0]` therefore rises exactly SETTLE_CYCLES edges after `cnt`.
- STEP: counter increments each unheld cycle.
  - When counter reaches STEP_CYCLES-1, the next edge sets the next bit (`cnt_step[step_idx]`), increments `step_idx` and clears the counter.
  - Bit k rises SETTLE_CYCLES + k*STEP_CYCLES edges after `cnt`.
  - On the edge that sets bit 40: `step_idx`=41, `done`=1, `busy`=0, state DONE.
- DONE: `cnt` and all `cnt_step` bits stay high; `done` is held.
  - `start`=1 → REARM: clears `cnt`, `cnt_step`, `step_idx` and `done` for exactly one cycle, then SETTLE as from IDLE. This guarantees the inverter sees a low enable between runs.
- Enables are sticky: once a `cnt_step` bit is set it stays set until REARM, abort or `rst`.
- Thermometer invariant: `cnt_step[k]` implies `cnt_step[k-1]`, and `popcount(cnt_step)` == `step_idx` at all times.
- `start` while in SETTLE or STEP is ignored, with no effect on timing.
- `hold`=1 in SETTLE or STEP freezes the counter and all outputs.
  - Progression resumes on the first cycle `hold` is low.
  - Every later rise is delayed by exactly the number of held cycles.
  - `hold` has no effect in IDLE or DONE.
- `abort`=1 in any non-IDLE state: the next edge clears all outputs and enters IDLE. A simultaneous `start` is ignored.
- Mid-run `rst`: identical to `abort`, and also overrides `start`.
- Counter width is clog2(max(SETTLE_CYCLES, STEP_CYCLES)+1). The counter never exceeds max-1.

Test Plan:
- Defaults, `start` pulsed at edge 0 → `cnt`=1 and `busy`=1 at edge 1; `cnt_step[0]` at edge 11; `cnt_step[k]` at edge 11+k; `cnt_step[40]`, `done`=1, `busy`=0 and `step_idx`=41 at edge 51; thermometer invariant checked every cycle.
- Defaults, `hold` high for 3 cycles after `cnt_step[5]` sets (edge 16) → `cnt_step[6]` at edge 20, `done` at edge 54.
- `start` re-pulsed at edges 5 and 30 during a run → timing identical to the first scenario; `done` still at edge 51.
- `abort` at edge 31 (`step_idx`=21) → edge 32: all outputs 0, IDLE; a new `start` at edge 40 → `cnt` at 41, `cnt_step[0]` at 51.
- SETTLE_CYCLES=2, STEP_CYCLES=3, `start` at edge 0 → `cnt_step[0]` at edge 3, `cnt_step[40]` and `done` at edge 123.
- In DONE, `start` at edge 60 → edge 61: all outputs 0; edge 62: `cnt`=1; `cnt_step[0]` at edge 72. Separately, `rst` at edge 20 with `start` high → all outputs 0 at edge 21, remaining IDLE.

Source files
------------

// File: rtl/matrix_inv_sequencer.sv
// matrix_inv_sequencer
//   Control stage in front of the 5x5 matrixInversion block. A single start
//   pulse raises the global enable `cnt`, waits SETTLE_CYCLES clocks, then
//   raises the sticky step enables cnt_step[0..NUM_STEPS-1] one after another,
//   spaced STEP_CYCLES clocks apart. Each cnt_step[k] is wired to matrixInversion
//   port cnt<k>.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   start     one-cycle request to begin a run (ignored while a run is active)
//   abort     synchronous abort, returns to IDLE with all outputs cleared
//   hold      freezes step progression while high (SETTLE/STEP only)
//   cnt       inverter global enable
//   cnt_step  thermometer of step enables, bit k -> matrixInversion cnt<k>
//   step_idx  number of cnt_step bits currently set
//   busy      high from the rise of cnt until done rises
//   done      high once the last step enable is set, held until rerun/abort
//
// Handshake: start/abort/hold are level-sampled on every rising edge; there is
// no ready/ack. A start that arrives while SETTLE or STEP is active is dropped.
//
// Edge priority: rst > abort > hold > normal progression.

module matrix_inv_sequencer #(
  parameter int SETTLE_CYCLES = 10,
  parameter int STEP_CYCLES   = 1,
  parameter int NUM_STEPS     = 41
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 hold,
  output logic                 cnt,
  output logic [NUM_STEPS-1:0] cnt_step,
  output logic [5:0]           step_idx,
  output logic                 busy,
  output logic                 done
);

  // One counter serves both the settle and the per-step interval, so it is
  // sized for the longer of the two.
  localparam int MAX_CYCLES = (SETTLE_CYCLES > STEP_CYCLES) ? SETTLE_CYCLES : STEP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_CYCLES - 1);
  localparam logic [5:0]    LAST_IDX    = 6'(NUM_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REARM  = 3'd1,
    SETTLE = 3'd2,
    STEP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Kept as a named register so checkers can bind to the FSM state directly.
  state_t        state;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      // abort in IDLE is harmless: everything is already clear there.
      state    <= IDLE;
      count    <= '0;
      cnt      <= 1'b0;
      cnt_step <= '0;
      step_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SETTLE;
            count <= '0;
            cnt   <= 1'b1;
            busy  <= 1'b1;
          end
        end

        // One guaranteed low-enable cycle between consecutive runs.
        REARM: begin
          state <= SETTLE;
          count <= '0;
          cnt   <= 1'b1;
          busy  <= 1'b1;
        end

        SETTLE: begin
          if (!hold) begin
            if (count == SETTLE_LAST) begin
              state    <= STEP;
              count    <= '0;
              cnt_step <= {cnt_step[NUM_STEPS-2:0], 1'b1};
              step_idx <= 6'd1;
            end else begin
              count <= count + CW'(1);
            end
          end
        end

        STEP: begin
          if (!hold) begin
            if (count == STEP_LAST) begin
              count    <= '0;
              // Shifting a 1 in from the bottom sets bit step_idx and keeps
              // the thermometer shape by construction.
              cnt_step <= {cnt_step[NUM_STEPS-2:0], 1'b1};
              step_idx <= step_idx + 6'd1;
              if (step_idx == LAST_IDX) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              count <= count + CW'(1);
            end
          end
        end

        DONE: begin
          if (start) begin
            state    <= REARM;
            count    <= '0;
            cnt      <= 1'b0;
            cnt_step <= '0;
            step_idx <= '0;
            done     <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          count    <= '0;
          cnt      <= 1'b0;
          cnt_step <= '0;
          step_idx <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
